// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter.
// A PicoBlaze write to TX_PORT_ID launches one command frame to the device.
// The ps2c/ps2d lines are open-drain; the *_oe outputs are active-high pull-low enables.
//
// state       | meaning
// ------------+----------------------------------------------------------------
// S_IDLE      | lines released, waiting for a command write
// S_INHIBIT   | clock held low for INHIBIT_CYCLES to abort any device traffic
// S_RTS       | request-to-send: clock released, data pulled low (start bit)
// S_DATA      | shift out data[7:0], parity, stop (release) on device clock falls
// S_WAIT_ACK  | one cycle after the ACK fall; ACK level was sampled on that fall
// S_WAIT_IDLE | wait for the device to release both lines before going idle
module ps2_host_tx #(
  parameter logic [7:0] TX_PORT_ID     = 8'h0B,
  parameter logic [7:0] STATUS_PORT_ID = 8'h0C,
  parameter int         INHIBIT_CYCLES = 10000,
  parameter int         TIMEOUT_CYCLES = 2000000,
  parameter int         FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] port_id,
  input  logic       write_strobe,
  input  logic [7:0] out_port,
  output logic [7:0] in_port,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err
);

  // One down-counter serves both the inhibit hold and the RTS-to-ACK timeout,
  // since the two intervals never overlap.
  localparam int TMR_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] INHIBIT_LOAD = TMR_W'(INHIBIT_CYCLES - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_DATA,
    S_WAIT_ACK,
    S_WAIT_IDLE
  } state_t;

  state_t state, state_nxt;

  logic [FILTER_LEN-1:0] c_hist;
  logic                  c_filt;
  logic                  c_fall;
  logic [9:0]            frame;
  logic [3:0]            bit_cnt;
  logic [TMR_W-1:0]      tmr;
  logic                  tmr_zero;

  logic accept;
  logic rts_enter;
  logic shift_bit;
  logic timeout;
  logic nack;
  logic finish;

  // A fall is the filtered clock level about to go 1->0 after FILTER_LEN agreeing low samples.
  assign c_fall   = c_filt && (c_hist == '0);
  assign tmr_zero = (tmr == '0);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode, datapath strobes and line drives.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    rts_enter = 1'b0;
    shift_bit = 1'b0;
    timeout   = 1'b0;
    nack      = 1'b0;
    finish    = 1'b0;
    ps2c_oe   = 1'b0;
    ps2d_oe   = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (write_strobe && (port_id == TX_PORT_ID)) begin
          accept    = 1'b1;
          state_nxt = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        ps2c_oe = 1'b1;
        if (tmr_zero) begin
          rts_enter = 1'b1;
          state_nxt = S_RTS;
        end
      end
      S_RTS: begin
        ps2d_oe = 1'b1;
        if (tmr_zero) begin
          timeout   = 1'b1;
          state_nxt = S_IDLE;
        end else if (c_fall) begin
          state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        ps2d_oe = ~frame[0];
        if (tmr_zero) begin
          timeout   = 1'b1;
          state_nxt = S_IDLE;
        end else if (c_fall) begin
          if (bit_cnt == 4'd9) begin
            // Fall after the stop bit: the device should be holding data low as ACK.
            nack      = ps2d_in;
            state_nxt = S_WAIT_ACK;
          end else begin
            shift_bit = 1'b1;
          end
        end
      end
      S_WAIT_ACK: begin
        if (tmr_zero) begin
          timeout   = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (c_filt && ps2d_in) begin
          finish    = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Clock filter, frame shifter, bit counter, shared timer and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      c_hist  <= '1;
      c_filt  <= 1'b1;
      frame   <= '1;
      bit_cnt <= '0;
      tmr     <= '0;
      tx_err  <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      c_hist <= {c_hist[FILTER_LEN-2:0], ps2c_in};
      if (c_hist == '0)      c_filt <= 1'b0;
      else if (c_hist == '1) c_filt <= 1'b1;

      tx_done <= finish && !tx_err;

      if (accept) begin
        // Stop bit above odd parity above the payload; bit 0 goes out first.
        frame   <= {1'b1, ~^out_port, out_port};
        bit_cnt <= '0;
        tmr     <= INHIBIT_LOAD;
        tx_err  <= 1'b0;
      end else begin
        if (rts_enter)      tmr <= TIMEOUT_LOAD;
        else if (!tmr_zero) tmr <= tmr - 1'b1;
        if (shift_bit) begin
          frame   <= {1'b1, frame[9:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end
        if (timeout || nack) tx_err <= 1'b1;
      end
    end
  end

  // Status read-back mux for the PicoBlaze input port.
  always_comb begin
    in_port = 8'h00;
    if (port_id == STATUS_PORT_ID) in_port = {5'b0, tx_err, ps2c_oe | ps2d_oe, busy};
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks the frame out of the DUT and
// compares received bits with values derived from the payload; a per-cycle process
// checks busy, idle lines, tx_done and the non-status read-back against the bench model.
module tb_ps2_host_tx;

  localparam int INH = 40;
  localparam int TMO = 3000;
  localparam int FL  = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] port_id = 8'h00;
  logic       write_strobe = 1'b0;
  logic [7:0] out_port = 8'h00;
  logic [7:0] in_port;
  logic       ps2c_in, ps2d_in;
  logic       ps2c_oe, ps2d_oe;
  logic       busy, tx_done, tx_err;

  logic dev_c_low = 1'b0;
  logic dev_d_low = 1'b0;

  // Wired-AND open-drain bus: either side may pull a line low.
  assign ps2c_in = ~(ps2c_oe | dev_c_low);
  assign ps2d_in = ~(ps2d_oe | dev_d_low);

  int nvec = 0;
  int nmis = 0;

  // Bench model: a transaction is in flight from the accepting edge until busy is seen low.
  bit m_active  = 1'b0;
  bit m_done_ok = 1'b0;

  ps2_host_tx #(
    .TX_PORT_ID    (8'h0B),
    .STATUS_PORT_ID(8'h0C),
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO),
    .FILTER_LEN    (FL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .port_id     (port_id),
    .write_strobe(write_strobe),
    .out_port    (out_port),
    .in_port     (in_port),
    .ps2c_in     (ps2c_in),
    .ps2d_in     (ps2d_in),
    .ps2c_oe     (ps2c_oe),
    .ps2d_oe     (ps2d_oe),
    .busy        (busy),
    .tx_done     (tx_done),
    .tx_err      (tx_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle compare against the bench model.
  always @(posedge clk) begin
    #3;
    if (!reset) begin
      chk_eq("oe_overlap", {31'b0, ps2c_oe & ps2d_oe}, 32'd0);
      chk_eq("busy_model", {31'b0, busy}, {31'b0, m_active});
      if (!m_active) chk_eq("idle_clk_released", {31'b0, ps2c_oe}, 32'd0);
      if (!m_done_ok) chk_eq("tx_done_spurious", {31'b0, tx_done}, 32'd0);
      if (port_id != 8'h0C) chk_eq("in_port_other", {24'b0, in_port}, 32'd0);
    end
  end

  task automatic write_port(input logic [7:0] pid, input logic [7:0] data);
    bit acc;
    acc = (pid == 8'h0B) && !m_active;
    port_id = pid;
    out_port = data;
    write_strobe = 1'b1;
    tick();
    write_strobe = 1'b0;
    port_id = 8'h00;
    if (acc) m_active = 1'b1;
  endtask

  task automatic read_status(input string name, input logic [7:0] exp);
    port_id = 8'h0C;
    #1;
    chk_eq(name, {24'b0, in_port}, {24'b0, exp});
    port_id = 8'h00;
  endtask

  // Device model for one frame. Data bits are read at the end of each clock-low phase.
  task automatic dev_frame(input logic [7:0] data, input bit ack, input int half,
                           input bit glitch, input bit abort4, input bit dup,
                           output logic [9:0] got);
    int n;
    bit par;
    got = '0;
    par = ($countones(data) % 2) == 0;
    n = 0;
    while (!ps2c_oe && n < 200) begin tick(); n++; end
    chk_eq("inhibit_start", {31'b0, ps2c_oe}, 32'd1);
    read_status("status_busy", 8'h03);
    n = 0;
    while (ps2c_oe && n < INH + 100) begin
      if (dup && n == 5) begin
        port_id = 8'h0B;
        out_port = 8'hAA;
        write_strobe = 1'b1;
      end
      tick();
      n++;
      write_strobe = 1'b0;
      port_id = 8'h00;
    end
    chk_eq("inhibit_len", n, INH);
    chk_eq("rts_start_bit", {31'b0, ps2d_in}, 32'd0);
    chk_eq("rts_clk_released", {31'b0, ps2c_in}, 32'd1);
    repeat ($urandom_range(20, 60)) tick();
    for (int i = 0; i < 10; i++) begin
      dev_c_low = 1'b1;
      repeat (half) tick();
      got[i] = ps2d_in;
      dev_c_low = 1'b0;
      if (abort4 && i == 3) begin
        chk_eq("abort_bits", {28'b0, got[3:0]}, {28'b0, data[3:0]});
        m_active = 1'b0;
        reset = 1'b1;
        tick();
        chk_eq("abort_clk", {31'b0, ps2c_oe}, 32'd0);
        chk_eq("abort_data", {31'b0, ps2d_oe}, 32'd0);
        chk_eq("abort_busy", {31'b0, busy}, 32'd0);
        chk_eq("abort_err", {31'b0, tx_err}, 32'd0);
        reset = 1'b0;
        return;
      end
      if (glitch && (i == 2 || i == 5)) begin
        repeat (6) tick();
        dev_c_low = 1'b1;
        repeat (5) tick();
        dev_c_low = 1'b0;
        repeat (half - 11) tick();
      end else begin
        repeat (half) tick();
      end
    end
    chk_eq("data_bits", {24'b0, got[7:0]}, {24'b0, data});
    chk_eq("parity_bit", {31'b0, got[8]}, {31'b0, par});
    chk_eq("stop_bit", {31'b0, got[9]}, 32'd1);
    dev_d_low = ack;
    if (ack) m_done_ok = 1'b1;
    dev_c_low = 1'b1;
    repeat (half) tick();
    dev_c_low = 1'b0;
    tick();
    dev_d_low = 1'b0;
    n = 0;
    while (busy && n < 200) begin tick(); n++; end
    m_active = 1'b0;
    chk_eq("busy_end", {31'b0, busy}, 32'd0);
    chk_eq("tx_done_pulse", {31'b0, tx_done}, {31'b0, ack});
    chk_eq("tx_err_end", {31'b0, tx_err}, {31'b0, !ack});
    tick();
    chk_eq("tx_done_width", {31'b0, tx_done}, 32'd0);
    m_done_ok = 1'b0;
  endtask

  initial begin
    logic [9:0] got;
    logic [7:0] d;
    logic [7:0] pid;
    int n;

    reset = 1'b1;
    tick();
    tick();
    chk_eq("rst_clk_oe", {31'b0, ps2c_oe}, 32'd0);
    chk_eq("rst_data_oe", {31'b0, ps2d_oe}, 32'd0);
    chk_eq("rst_busy", {31'b0, busy}, 32'd0);
    chk_eq("rst_done", {31'b0, tx_done}, 32'd0);
    chk_eq("rst_err", {31'b0, tx_err}, 32'd0);
    read_status("rst_status", 8'h00);
    reset = 1'b0;
    repeat (FL + 2) tick();

    // 0xED with ACK: bits LSB first 1,0,1,1,0,1,1,1, parity 1, stop 1.
    write_port(8'h0B, 8'hED);
    dev_frame(8'hED, 1'b1, 30, 1'b0, 1'b0, 1'b0, got);
    chk_eq("ed_frame_literal", {22'b0, got}, 32'h3ED);
    read_status("status_ok", 8'h00);

    // 0xFF without ACK.
    write_port(8'h0B, 8'hFF);
    dev_frame(8'hFF, 1'b0, 25, 1'b0, 1'b0, 1'b0, got);
    chk_eq("ff_frame_literal", {22'b0, got}, 32'h3FF);
    read_status("status_nack", 8'h04);

    // 0x00 with a silent device: timeout counted from RTS entry.
    write_port(8'h0B, 8'h00);
    read_status("status_err_cleared", 8'h03);
    n = 0;
    while (ps2c_oe && n < INH + 100) begin tick(); n++; end
    chk_eq("tmo_inhibit_len", n, INH);
    n = 0;
    while (busy && n < TMO + 50) begin tick(); n++; end
    m_active = 1'b0;
    chk_eq("tmo_cycles", n, TMO);
    chk_eq("tmo_clk_oe", {31'b0, ps2c_oe}, 32'd0);
    chk_eq("tmo_data_oe", {31'b0, ps2d_oe}, 32'd0);
    chk_eq("tmo_err", {31'b0, tx_err}, 32'd1);
    read_status("status_tmo", 8'h04);
    repeat (FL + 2) tick();

    // 0xF4 with a second write during the frame; parity 0.
    write_port(8'h0B, 8'hF4);
    dev_frame(8'hF4, 1'b1, 22, 1'b0, 1'b0, 1'b1, got);
    chk_eq("f4_frame_literal", {22'b0, got}, 32'h2F4);
    repeat (60) tick();
    chk_eq("no_second_frame", {31'b0, busy}, 32'd0);

    // Reset after the fourth data bit, then a fresh frame.
    write_port(8'h0B, 8'hED);
    dev_frame(8'hED, 1'b1, 30, 1'b0, 1'b1, 1'b0, got);
    repeat (FL + 2) tick();
    write_port(8'h0B, 8'hED);
    dev_frame(8'hED, 1'b1, 30, 1'b0, 1'b0, 1'b0, got);
    chk_eq("ed_after_reset", {22'b0, got}, 32'h3ED);

    // Writes to other ports do nothing; short clock glitches do not advance the frame.
    write_port(8'h0A, 8'h55);
    write_port(8'h6A, 8'hED);
    repeat (50) tick();
    chk_eq("other_port_idle", {31'b0, busy}, 32'd0);
    write_port(8'h0B, 8'h5A);
    dev_frame(8'h5A, 1'b1, 30, 1'b1, 1'b0, 1'b0, got);

    // Randomized frames.
    for (int k = 0; k < 8; k++) begin
      pid = 8'($urandom_range(0, 255));
      if (pid == 8'h0B || pid == 8'h0C) pid = 8'h3C;
      write_port(pid, 8'($urandom));
      repeat ($urandom_range(FL + 2, 30)) tick();
      d = 8'($urandom);
      write_port(8'h0B, d);
      dev_frame(d, ($urandom % 4) != 0, $urandom_range(20, 40), 1'($urandom % 2),
                1'b0, 1'($urandom % 2), got);
      repeat ($urandom_range(FL + 2, 30)) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
